// File: rtl/fir_err_monitor.sv
// -----------------------------------------------------------------------------
// fir_err_monitor
//
// Measures the error of an approximate-adder FIR against an exact-adder FIR
// over a window of WIN = 2**LOG2WIN accepted samples. The block computes the
// sum of absolute differences, the largest absolute difference, the number of
// samples that differ, and the mean absolute difference.
//
// Parameters
//   LOG2WIN  window length exponent, 1..16 (WIN = 2**LOG2WIN)
//   W        sample width in bits
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     begin a new window (sampled only in IDLE or DONE)
//   in_valid  approx/exact pair valid this cycle
//   approx    approximate FIR output, unsigned
//   exact     exact FIR output for the same input sample, unsigned
//   busy      high while a window is being collected or drained
//   done      one-cycle pulse when the results are final
//   sad       sum of |approx-exact| over the window
//   max_err   largest |approx-exact| in the window
//   err_cnt   number of samples with approx != exact
//   mean_err  sad >> LOG2WIN, truncated
//
// Timing: the clock edge that accepts the last sample of a window fills the
// sample counter. In the following cycle the FSM sees the full counter and
// moves to DRAIN, which lasts two cycles, so done is high in the fourth cycle
// after the accepting edge. The pipeline is empty long before then; the
// DRAIN cycles keep the result timing fixed regardless of pipeline depth.
// -----------------------------------------------------------------------------
module fir_err_monitor #(
    parameter int LOG2WIN = 8,
    parameter int W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     approx,
    input  logic [W-1:0]     exact,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sad,
    output logic [W-1:0]     max_err,
    output logic [16:0]      err_cnt,
    output logic [W-1:0]     mean_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Terminal value of the sample counter: exactly WIN, no wrap-around.
    localparam logic [LOG2WIN:0] WIN_CNT = {1'b1, {LOG2WIN{1'b0}}};

    // Absolute difference using a W+1-bit subtraction; the extra bit is the
    // borrow that tells which operand was larger.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[W]) begin
            abs_diff = b - a;
        end else begin
            abs_diff = diff[W-1:0];
        end
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic               accept_s;
    logic               clear_s;
    logic               drain_r;
    logic [LOG2WIN:0]   cnt_r;

    logic               s1_valid_r;
    logic [W-1:0]       s1_d_r;
    logic               s1_ne_r;

    logic [31:0]        sad_r;
    logic [W-1:0]       max_r;
    logic [16:0]        err_cnt_r;
    logic               busy_r;
    logic               done_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic plus the accept/clear strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    clear_s      = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                // Once the counter is full the window is closed; any further
                // in_valid is ignored while the FSM heads for DRAIN.
                if (cnt_r == WIN_CNT) begin
                    next_state_s = DRAIN;
                end else begin
                    accept_s     = in_valid;
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE: begin
                if (start) begin
                    clear_s      = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // DRAIN cycle tracker: 0 in the first DRAIN cycle, 1 in the second.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_r <= 1'b0;
        end else if (state_r == DRAIN) begin
            drain_r <= ~drain_r;
        end else begin
            drain_r <= 1'b0;
        end
    end

    // Accepted-sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear_s) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + (LOG2WIN+1)'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pipeline stage 1: absolute difference and nonzero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_d_r     <= '0;
            s1_ne_r    <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_d_r  <= abs_diff(approx, exact);
                s1_ne_r <= (approx != exact);
            end else begin
                s1_d_r  <= s1_d_r;
                s1_ne_r <= s1_ne_r;
            end
        end
    end

    // Pipeline stage 2: accumulators. A clear can never coincide with a valid
    // stage-1 entry because stage 1 is empty in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sad_r     <= 32'd0;
            max_r     <= '0;
            err_cnt_r <= 17'd0;
        end else if (clear_s) begin
            sad_r     <= 32'd0;
            max_r     <= '0;
            err_cnt_r <= 17'd0;
        end else if (s1_valid_r) begin
            sad_r     <= sad_r + 32'(s1_d_r);
            err_cnt_r <= err_cnt_r + 17'(s1_ne_r);
            if (s1_d_r > max_r) begin
                max_r <= s1_d_r;
            end else begin
                max_r <= max_r;
            end
        end else begin
            sad_r     <= sad_r;
            max_r     <= max_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    // Status outputs registered from the next state so they track the FSM
    // state exactly, with no decode glitches on the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN) || (next_state_s == DRAIN);
            done_r <= (next_state_s == DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sad      = sad_r;
    assign max_err  = max_r;
    assign err_cnt  = err_cnt_r;
    // Mean is a plain bit-select of the registered sum; it always fits in W
    // bits because every term is at most 2**W-1.
    assign mean_err = sad_r[LOG2WIN +: W];

endmodule

// File: tb/tb_fir_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_fir_err_monitor
//
// Two instances share clock, reset and stimulus: one with LOG2WIN=2 for the
// directed and short randomized windows, one with the default LOG2WIN=8 for
// the long random window. Only the instance under test in a given scenario is
// checked. Expected results come from a queue of the pairs sent to the window,
// reduced with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fir_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] approx;
    logic [15:0] exact;

    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] sad_a, sad_b;
    logic [15:0] max_a, max_b, mean_a, mean_b;
    logic [16:0] cnt_a, cnt_b;

    int checks_n = 0;
    int errors_n = 0;

    // Pairs (and idle gaps before each) for the window being sent.
    logic [15:0] in_a[$];
    logic [15:0] in_e[$];
    int          in_g[$];

    fir_err_monitor #(.LOG2WIN(2), .W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .approx(approx), .exact(exact), .busy(busy_a), .done(done_a),
        .sad(sad_a), .max_err(max_a), .err_cnt(cnt_a), .mean_err(mean_a)
    );

    fir_err_monitor #(.LOG2WIN(8), .W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .approx(approx), .exact(exact), .busy(busy_b), .done(done_b),
        .sad(sad_b), .max_err(max_b), .err_cnt(cnt_b), .mean_err(mean_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic cur_done(input int l2);
        return (l2 == 2) ? done_a : done_b;
    endfunction

    function automatic logic cur_busy(input int l2);
        return (l2 == 2) ? busy_a : busy_b;
    endfunction

    task automatic check_results(input string tag, input int l2,
                                 input logic [31:0] s, input logic [31:0] mx,
                                 input logic [31:0] ne);
        check_val({tag, "_sad"},  (l2 == 2) ? sad_a : sad_b, s);
        check_val({tag, "_max"},  (l2 == 2) ? 32'(max_a) : 32'(max_b), mx);
        check_val({tag, "_cnt"},  (l2 == 2) ? 32'(cnt_a) : 32'(cnt_b), ne);
        check_val({tag, "_mean"}, (l2 == 2) ? 32'(mean_a) : 32'(mean_b),
                  s >> l2);
    endtask

    task automatic clear_q();
        in_a.delete();
        in_e.delete();
        in_g.delete();
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] e,
                        input int g);
        in_a.push_back(a);
        in_e.push_back(e);
        in_g.push_back(g);
    endtask

    // Random pairs biased towards equal values and small differences.
    task automatic fill_rand(input int n, input int max_gap);
        logic [15:0] a, e;
        clear_q();
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: e = a;
                1: e = a + 16'($urandom_range(0, 7)) - 16'd3;
                default: e = 16'($urandom);
            endcase
            push(a, e, int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive the queued pairs; gap cycles carry random data with in_valid=0.
    task automatic send(input string tag, input int l2, input bit poke_start);
        bit early;
        early = 1'b0;
        for (int i = 0; i < in_a.size(); i++) begin
            for (int g = 0; g < in_g[i]; g++) begin
                in_valid = 1'b0;
                approx   = 16'($urandom);
                exact    = 16'($urandom);
                start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                early |= cur_done(l2);
            end
            in_valid = 1'b1;
            approx   = in_a[i];
            exact    = in_e[i];
            start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (i < in_a.size() - 1) early |= cur_done(l2);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check_val({tag, "_no_early_done"}, 32'(early), 32'd0);
    endtask

    // Called at the falling edge right after the edge that accepted the last
    // sample. done must appear in the fourth cycle after that edge.
    task automatic expect_window(input string tag, input int l2,
                                 input bit hold);
        longint s;
        int     mx, ne, d;
        bit     early, busy_ok;
        s = 0; mx = 0; ne = 0;
        for (int i = 0; i < in_a.size(); i++) begin
            d = int'(in_a[i]) - int'(in_e[i]);
            if (d < 0) d = -d;
            s += d;
            if (d > mx) mx = d;
            if (d != 0) ne++;
        end
        early = 1'b0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            early   |= cur_done(l2);
            busy_ok &= cur_busy(l2);
            in_valid = 1'b1;
            approx   = 16'($urandom);
            exact    = 16'($urandom);
            start    = (c == 3) ? hold : 1'($urandom_range(0, 1));
            step();
        end
        check_val({tag, "_done_early"}, 32'(early), 32'd0);
        check_val({tag, "_busy_drain"}, 32'(busy_ok), 32'd1);
        check_val({tag, "_done"}, 32'(cur_done(l2)), 32'd1);
        check_val({tag, "_busy_done"}, 32'(cur_busy(l2)), 32'd0);
        check_results(tag, l2, 32'(s), 32'(mx), 32'(ne));
        step();
        in_valid = 1'b0;
        start    = 1'b0;
        check_val({tag, "_done_pulse"}, 32'(cur_done(l2)), 32'd0);
        check_val({tag, "_busy_after"}, 32'(cur_busy(l2)), 32'(hold));
        if (hold) begin
            check_results({tag, "_cleared"}, l2, 32'd0, 32'd0, 32'd0);
        end else begin
            step();
            step();
            check_results({tag, "_held"}, l2, 32'(s), 32'(mx), 32'(ne));
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        start    = 1'b1;
        approx   = 16'($urandom);
        exact    = 16'($urandom);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // After a reset: idle, zero outputs, and no done pulse for a while.
    task automatic check_after_reset(input string tag, input int l2);
        bit seen;
        check_val({tag, "_busy"}, 32'(cur_busy(l2)), 32'd0);
        check_val({tag, "_done"}, 32'(cur_done(l2)), 32'd0);
        check_results(tag, l2, 32'd0, 32'd0, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= cur_done(l2) | cur_busy(l2);
        end
        check_val({tag, "_quiet"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        approx = 16'd0; exact = 16'd0;
        @(negedge clk);
        do_reset();
        check_after_reset("reset_a", 2);
        check_results("reset_b", 8, 32'd0, 32'd0, 32'd0);

        // Identical pairs give zero error.
        clear_q();
        for (int i = 0; i < 4; i++) push(16'h1234, 16'h1234, 0);
        do_start();
        check_val("t_equal_busy", 32'(busy_a), 32'd1);
        send("t_equal", 2, 1'b0);
        expect_window("t_equal", 2, 1'b0);

        // Both signs of difference and the full-scale difference.
        clear_q();
        push(16'd10, 16'd7, 0);
        push(16'd7, 16'd10, 0);
        push(16'd0, 16'd0, 0);
        push(16'hFFFF, 16'd0, 0);
        do_start();
        send("t_pairs", 2, 1'b0);
        expect_window("t_pairs", 2, 1'b0);

        // Gapped valid pattern 1,0,0,1,1,0,1.
        clear_q();
        push(16'd5, 16'd1, 0);
        push(16'd5, 16'd1, 2);
        push(16'd5, 16'd1, 0);
        push(16'd5, 16'd1, 1);
        do_start();
        send("t_gap", 2, 1'b0);
        expect_window("t_gap", 2, 1'b0);

        // Back-to-back windows with start held through DONE, then a window
        // with random start pulses while running.
        fill_rand(4, 1);
        do_start();
        send("t_b2b1", 2, 1'b0);
        expect_window("t_b2b1", 2, 1'b1);
        fill_rand(4, 2);
        send("t_b2b2", 2, 1'b1);
        expect_window("t_b2b2", 2, 1'b0);

        // Reset after two of four samples.
        fill_rand(2, 0);
        do_start();
        send("t_rst_run", 2, 1'b0);
        do_reset();
        check_after_reset("t_rst_run", 2);
        fill_rand(4, 1);
        do_start();
        send("t_fresh", 2, 1'b0);
        expect_window("t_fresh", 2, 1'b0);

        // Reset in the middle of DRAIN.
        fill_rand(4, 0);
        do_start();
        send("t_rst_drain", 2, 1'b0);
        step();
        step();
        do_reset();
        check_after_reset("t_rst_drain", 2);

        // A few more random short windows.
        for (int k = 0; k < 4; k++) begin
            fill_rand(4, 2);
            do_start();
            send("t_rand_a", 2, 1'b1);
            expect_window("t_rand_a", 2, 1'b0);
        end

        // Default window length with random 16-bit pairs.
        do_reset();
        check_results("t_win256_rst", 8, 32'd0, 32'd0, 32'd0);
        fill_rand(256, 1);
        do_start();
        send("t_win256", 8, 1'b1);
        expect_window("t_win256", 8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
